// File: rtl/rr_arbiter_4ch_pkg.sv
// rr_arbiter_4ch_pkg: shared constants for the 4-channel round-robin arbiter.
//   CH_NUM  - number of request channels
//   SEL_W   - width of a channel index
//   PTR_RST - pointer value after reset (last-granted = 3, so channel 0 goes first)
package rr_arbiter_4ch_pkg;
  localparam int CH_NUM = 4;
  localparam int SEL_W = 2;
  localparam logic [SEL_W-1:0] PTR_RST = 2'd3;
endpackage

// File: rtl/rr_arbiter_4ch_pick4.sv
// rr_pick4: rotating-priority pick among four requests.
//   req     - per-channel request bits
//   ptr     - index of the last granted channel
//   pick    - first requester scanning ptr+1, ptr+2, ptr+3, ptr; equals ptr when idle
//   any_req - at least one request is present
module rr_pick4
  import rr_arbiter_4ch_pkg::*;
(
  input  logic [CH_NUM-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  pick,
  output logic              any_req
);
  assign any_req = |req;
  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    pick = ptr;
    for (int k = 3; k >= 0; k--)
      if (req[ptr + 2'(k) + 2'd1]) pick = ptr + 2'(k) + 2'd1;
  end
endmodule

// File: rtl/rr_arbiter_4ch.sv
// rr_arbiter_4ch: 4-channel round-robin arbiter feeding a single registered output word.
//   clk, rst_n          - clock, asynchronous active-low reset
//   req, w0..w3         - per-channel request and data word
//   gnt                 - one-hot capture strobe for the granted channel
//   s                   - channel index steering the 4:1 data select
//   f, f_ch, f_valid    - registered output word, its source channel and valid flag
//   f_ready             - downstream accepts f this cycle
module rr_arbiter_4ch
  import rr_arbiter_4ch_pkg::*;
#(
  parameter int n = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH_NUM-1:0] req,
  input  logic [n-1:0]      w0,
  input  logic [n-1:0]      w1,
  input  logic [n-1:0]      w2,
  input  logic [n-1:0]      w3,
  output logic [CH_NUM-1:0] gnt,
  output logic [SEL_W-1:0]  s,
  output logic              f_valid,
  input  logic              f_ready,
  output logic [n-1:0]      f,
  output logic [SEL_W-1:0]  f_ch
);
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] pick;
  logic             any_req;
  logic             load;
  logic [n-1:0]     w_sel;
  rr_pick4 u_pick (
    .req     (req),
    .ptr     (ptr),
    .pick    (pick),
    .any_req (any_req)
  );
  // rst_n gates the load so no grant is issued while reset is held.
  assign load  = rst_n & any_req & (~f_valid | f_ready);
  assign gnt   = load ? 4'b0001 << pick : '0;
  assign s     = pick;
  assign w_sel = pick == 2'd0 ? w0 : pick == 2'd1 ? w1 : pick == 2'd2 ? w2 : w3;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= PTR_RST;
      f_valid <= 1'b0;
      f       <= '0;
      f_ch    <= '0;
    end else if (load) begin
      ptr     <= pick;
      f_valid <= 1'b1;
      f       <= w_sel;
      f_ch    <= pick;
    end else if (f_ready) begin
      f_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_arbiter_4ch.sv
// tb_rr_arbiter_4ch: randomized and directed checks of rr_arbiter_4ch against a queue-free reference model.
module tb_rr_arbiter_4ch;
  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [2:0] w [4];
  logic [3:0] gnt;
  logic [1:0] s;
  logic       f_valid;
  logic       f_ready;
  logic [2:0] f;
  logic [1:0] f_ch;
  int vectors = 0;
  int miscompares = 0;
  int m_ptr;
  int m_valid;
  int m_f;
  int m_ch;
  rr_arbiter_4ch #(.n(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .w0      (w[0]),
    .w1      (w[1]),
    .w2      (w[2]),
    .w3      (w[3]),
    .gnt     (gnt),
    .s       (s),
    .f_valid (f_valid),
    .f_ready (f_ready),
    .f       (f),
    .f_ch    (f_ch)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int exp_pick();
    for (int k = 1; k <= 4; k++)
      if (req[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return m_ptr;
  endfunction
  function automatic logic [3:0] exp_gnt();
    if (rst_n && req != 0 && (m_valid == 0 || f_ready)) return 4'(1 << exp_pick());
    return 4'b0000;
  endfunction
  task automatic model_reset();
    m_ptr = 3;
    m_valid = 0;
    m_f = 0;
    m_ch = 0;
  endtask
  task automatic cyc();
    int p;
    @(posedge clk);
    if (rst_n) begin
      if (req != 0 && (m_valid == 0 || f_ready)) begin
        p = exp_pick();
        m_f = int'(w[p]);
        m_ch = p;
        m_valid = 1;
        m_ptr = p;
      end else if (m_valid != 0 && f_ready) m_valid = 0;
    end
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b0000;
    f_ready = 1'b1;
    foreach (w[i]) w[i] = 3'(i + 1);
    model_reset();
    #1;
    vectors++;
    if (f_valid !== 1'b0 || f !== 3'd0 || f_ch !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: f_valid=%b f=%0d f_ch=%0d, required 0 0 0", f_valid, f, f_ch);
    end
    vectors++;
    if (s !== 2'd3) begin
      miscompares++;
      $display("FAIL reset_ptr: s=%0d, required 3", s);
    end
    req = 4'b1111;
    #1;
    vectors++;
    if (gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_gnt: gnt=%b, required 0000", gnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_first_gnt: gnt=%b, required 0001", gnt);
    end
    cyc();
    vectors++;
    if (f_valid !== 1'b1 || f !== 3'd1 || f_ch !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_first_load: f_valid=%b f=%0d f_ch=%0d, required 1 1 0", f_valid, f, f_ch);
    end
  endtask
  task automatic test_reset_mid();
    req = 4'b1111;
    f_ready = 1'b1;
    repeat (2) cyc();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (f_valid !== 1'b0 || f !== 3'd0 || gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_reset: f_valid=%b f=%0d gnt=%b, required 0 0 0000", f_valid, f, gnt);
    end
    req = 4'b0000;
    #1;
    vectors++;
    if (s !== 2'd3) begin
      miscompares++;
      $display("FAIL mid_reset_ptr: s=%0d, required 3", s);
    end
    req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL mid_reset_first_gnt: gnt=%b, required 0001", gnt);
    end
    cyc();
  endtask
  task automatic test_all_request();
    rst_n = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b1;
    req = 4'b1111;
    f_ready = 1'b1;
    foreach (w[i]) w[i] = 3'(i + 1);
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (gnt !== 4'(1 << (i % 4)) || gnt !== exp_gnt()) begin
        miscompares++;
        $display("FAIL all_req_gnt[%0d]: gnt=%b, required %b", i, gnt, 4'(1 << (i % 4)));
      end
      cyc();
      vectors++;
      if (f !== 3'((i % 4) + 1) || f_ch !== 2'(i % 4)) begin
        miscompares++;
        $display("FAIL all_req_f[%0d]: f=%0d f_ch=%0d, required %0d %0d", i, f, f_ch, (i % 4) + 1, i % 4);
      end
    end
  endtask
  task automatic test_back_pressure();
    f_ready = 1'b1;
    req = 4'b0001;
    w[0] = 3'd5;
    cyc();
    f_ready = 1'b0;
    req = 4'b0100;
    w[2] = 3'd6;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (gnt !== 4'b0000) begin
        miscompares++;
        $display("FAIL bp_gnt[%0d]: gnt=%b, required 0000", i, gnt);
      end
      cyc();
      vectors++;
      if (f !== 3'd5 || f_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: f=%0d f_valid=%b, required 5 1", i, f, f_valid);
      end
    end
    f_ready = 1'b1;
    #1;
    vectors++;
    if (gnt !== 4'b0100) begin
      miscompares++;
      $display("FAIL bp_release_gnt: gnt=%b, required 0100", gnt);
    end
    cyc();
    vectors++;
    if (f !== 3'd6 || f_ch !== 2'd2) begin
      miscompares++;
      $display("FAIL bp_release_f: f=%0d f_ch=%0d, required 6 2", f, f_ch);
    end
  endtask
  task automatic test_wrap_skip();
    f_ready = 1'b1;
    req = 4'b0100;
    cyc();
    req = 4'b1001;
    #1;
    vectors++;
    if (gnt !== 4'b1000 || s !== 2'd3) begin
      miscompares++;
      $display("FAIL wrap_pick3: gnt=%b s=%0d, required 1000 3", gnt, s);
    end
    cyc();
    req = 4'b0001;
    #1;
    vectors++;
    if (gnt !== 4'b0001 || s !== 2'd0) begin
      miscompares++;
      $display("FAIL wrap_pick0: gnt=%b s=%0d, required 0001 0", gnt, s);
    end
    cyc();
  endtask
  task automatic test_drain();
    logic [2:0] held;
    f_ready = 1'b1;
    req = 4'b0010;
    w[1] = 3'd7;
    cyc();
    held = f;
    req = 4'b0000;
    #1;
    vectors++;
    if (gnt !== 4'b0000 || s !== 2'd1) begin
      miscompares++;
      $display("FAIL drain_idle: gnt=%b s=%0d, required 0000 1", gnt, s);
    end
    cyc();
    vectors++;
    if (f_valid !== 1'b0 || f !== 3'd7 || f_ch !== 2'd1) begin
      miscompares++;
      $display("FAIL drain_empty: f_valid=%b f=%0d f_ch=%0d, required 0 7 1 (held %0d)", f_valid, f, f_ch, held);
    end
  endtask
  task automatic test_single();
    logic [2:0] sent;
    f_ready = 1'b1;
    req = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      w[1] = 3'($urandom_range(7));
      sent = w[1];
      #1;
      vectors++;
      if (gnt !== 4'b0010) begin
        miscompares++;
        $display("FAIL single_gnt[%0d]: gnt=%b, required 0010", i, gnt);
      end
      cyc();
      vectors++;
      if (f !== sent || f_ch !== 2'd1 || f_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL single_f[%0d]: f=%0d f_ch=%0d f_valid=%b, required %0d 1 1", i, f, f_ch, f_valid, sent);
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      req = 4'($urandom_range(15));
      f_ready = ($urandom_range(3) != 0);
      foreach (w[j]) w[j] = 3'($urandom_range(7));
      #1;
      vectors++;
      if (gnt !== exp_gnt() || s !== 2'(exp_pick())) begin
        miscompares++;
        $display("FAIL rand_comb[%0d]: gnt=%b s=%0d, required %b %0d", i, gnt, s, exp_gnt(), exp_pick());
      end
      cyc();
      vectors++;
      if (f_valid !== 1'(m_valid) || f !== 3'(m_f) || f_ch !== 2'(m_ch)) begin
        miscompares++;
        $display("FAIL rand_reg[%0d]: f_valid=%b f=%0d f_ch=%0d, required %0d %0d %0d", i, f_valid, f, f_ch, m_valid, m_f, m_ch);
      end
    end
  endtask
  initial begin
    rst_n = 1'b0;
    req = 4'b0000;
    f_ready = 1'b0;
    foreach (w[i]) w[i] = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_all_request();
    test_back_pressure();
    test_wrap_skip();
    test_drain();
    test_single();
    test_random();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
